// File: rtl/sym_fir_cfg.sv
// Symmetric (folded) FIR with double-banked, run-time reloadable coefficients.
// Writes go to the shadow bank; a requested swap takes effect on the next sample enable.
module sym_fir_cfg #(
   parameter int WIDTH     = 18,
   parameter int LENGTH    = 93,
   parameter int OUT_SHIFT = 17,
   parameter int AW        = $clog2((LENGTH + 1) / 2)
) (
   input  logic                    sys_clk,
   input  logic                    reset,
   input  logic                    sam_clk_en,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic                    coef_wr,
   input  logic [AW-1:0]           coef_addr,
   input  logic signed [WIDTH-1:0] coef_data,
   input  logic                    coef_swap,
   output logic                    swap_pending,
   output logic signed [WIDTH-1:0] y,
   output logic                    y_valid
);

   localparam int NC   = (LENGTH + 1) / 2;
   localparam int MID  = (LENGTH - 1) / 2;
   localparam int PW   = 2 * WIDTH + 1;
   localparam int GB   = $clog2(NC);
   localparam int ACCW = PW + GB;
   localparam int RW   = ACCW + 1;

   localparam logic signed [WIDTH-1:0] C_UNITY = WIDTH'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [RW-1:0]    HALF    = RW'(1) << (OUT_SHIFT - 1);
   localparam logic signed [RW-1:0]    Y_MAX   = RW'((64'sd1 <<< (WIDTH - 1)) - 64'sd1);
   localparam logic signed [RW-1:0]    Y_MIN   = RW'(-(64'sd1 <<< (WIDTH - 1)));

   logic signed [WIDTH-1:0] tap_q  [LENGTH];
   logic signed [WIDTH-1:0] tap_d  [LENGTH];
   logic signed [WIDTH-1:0] bank_q [2][NC];
   logic signed [WIDTH-1:0] bank_d [2][NC];
   logic signed [PW-1:0]    p_q    [NC];
   logic signed [PW-1:0]    p_d    [NC];
   logic                    bank_sel_q, bank_sel_d;
   logic                    swap_pending_q, swap_pending_d;
   logic signed [WIDTH-1:0] y_q, y_d;
   logic                    y_valid_q, y_valid_d;
   logic [1:0]              prime_q, prime_d;

   logic                    swap_now;
   logic [NC-1:0]           wr_hit;
   logic signed [WIDTH-1:0] c_act  [NC];
   logic signed [WIDTH:0]   preadd [NC];
   logic signed [PW-1:0]    prod   [NC];
   logic signed [ACCW-1:0]  acc;
   logic signed [RW-1:0]    rnd;
   logic signed [WIDTH-1:0] y_sat;

   always_comb begin : swap_ctrl
      swap_now       = sam_clk_en && (swap_pending_q || coef_swap);
      bank_sel_d     = swap_now ? ~bank_sel_q : bank_sel_q;
      swap_pending_d = swap_now ? 1'b0 : (swap_pending_q || coef_swap);
   end

   genvar gi;
   generate
      for (gi = 0; gi < NC; gi++) begin : g_coef
         // Addresses at or above NC match no slot, so such writes vanish.
         assign wr_hit[gi] = coef_wr && (coef_addr == AW'(gi));

         // On a swapping enable the incoming bank is used, including a write on that same edge.
         assign c_act[gi] = !swap_now ? bank_q[bank_sel_q][gi]
                          : (wr_hit[gi] ? coef_data : bank_q[~bank_sel_q][gi]);

         if (gi < NC - 1) begin : g_pair
            assign preadd[gi] = $signed({tap_q[gi][WIDTH-1], tap_q[gi]})
                              + $signed({tap_q[LENGTH-1-gi][WIDTH-1], tap_q[LENGTH-1-gi]});
         end else begin : g_centre
            assign preadd[gi] = $signed({tap_q[MID][WIDTH-1], tap_q[MID]});
         end

         assign prod[gi] = $signed({{WIDTH{preadd[gi][WIDTH]}}, preadd[gi]})
                         * $signed({{(WIDTH + 1){c_act[gi][WIDTH-1]}}, c_act[gi]});
      end
   endgenerate

   always_comb begin : bank_next
      bank_d = bank_q;
      for (int k = 0; k < NC; k++) begin
         if (wr_hit[k]) begin
            bank_d[~bank_sel_q][k] = coef_data;
         end
      end
   end

   always_comb begin : taps_next
      tap_d = tap_q;
      if (sam_clk_en) begin
         tap_d[0] = x_in;
         for (int i = 1; i < LENGTH; i++) begin
            tap_d[i] = tap_q[i-1];
         end
      end
   end

   always_comb begin : products_next
      p_d = p_q;
      if (sam_clk_en) begin
         for (int k = 0; k < NC; k++) begin
            p_d[k] = prod[k];
         end
      end
   end

   always_comb begin : accumulate
      acc = '0;
      for (int k = 0; k < NC; k++) begin
         acc = acc + ACCW'(p_q[k]);
      end
      rnd = (RW'(acc) + HALF) >>> OUT_SHIFT;
      if (rnd > Y_MAX) begin
         y_sat = Y_MAX[WIDTH-1:0];
      end else if (rnd < Y_MIN) begin
         y_sat = Y_MIN[WIDTH-1:0];
      end else begin
         y_sat = rnd[WIDTH-1:0];
      end
   end

   // The first two enables after reset only flush the product and output stages.
   always_comb begin : output_next
      y_d       = y_q;
      y_valid_d = 1'b0;
      prime_d   = prime_q;
      if (sam_clk_en) begin
         y_d       = y_sat;
         y_valid_d = (prime_q == 2'd2);
         if (prime_q != 2'd2) begin
            prime_d = prime_q + 2'd1;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LENGTH; i++) begin
            tap_q[i] <= '0;
         end
         for (int k = 0; k < NC; k++) begin
            p_q[k]       <= '0;
            bank_q[0][k] <= (k == NC - 1) ? C_UNITY : '0;
            bank_q[1][k] <= '0;
         end
         bank_sel_q     <= 1'b0;
         swap_pending_q <= 1'b0;
         y_q            <= '0;
         y_valid_q      <= 1'b0;
         prime_q        <= 2'd0;
      end else begin
         tap_q          <= tap_d;
         p_q            <= p_d;
         bank_q         <= bank_d;
         bank_sel_q     <= bank_sel_d;
         swap_pending_q <= swap_pending_d;
         y_q            <= y_d;
         y_valid_q      <= y_valid_d;
         prime_q        <= prime_d;
      end
   end

   assign swap_pending = swap_pending_q;
   assign y            = y_q;
   assign y_valid      = y_valid_q;

endmodule
